// File: rtl/burst_serializer.sv
// rtl/burst_serializer.sv - parallel burst in, fixed latency, serial word-per-ce out
// Optional build macro: BURST_SERIALIZER_REVERSE_EN (emit words M-1 down to 0)
module burst_serializer #(
  parameter int INITIAL_LATENCY = 3,
  parameter int M               = 5,
  parameter int PRECISION       = 5
) (
  input  logic                            clk,
  input  logic                            clr_n,
  input  logic                            ce,
  input  logic                            load,
  input  logic [M-1:0][PRECISION-1:0]     data_in,
  output logic                            ready,
  output logic [PRECISION-1:0]            data_out,
  output logic                            data_valid,
  output logic                            burst_last,
  output logic                            burst_done
);

  localparam int MAXV = (INITIAL_LATENCY > M) ? INITIAL_LATENCY : M;
  localparam int CW   = $clog2(MAXV) + 1;
  localparam logic [CW-1:0] LAT_LAST = CW'(INITIAL_LATENCY - 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(M - 1);
  localparam logic [CW-1:0] M_END    = CW'(M);
`ifdef BURST_SERIALIZER_REVERSE_EN
  localparam bit REVERSE = 1'b1;
`else
  localparam bit REVERSE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LATENCY, STREAMING} state_t;

  state_t                        state, state_nx;
  logic [CW-1:0]                 count, count_nx;
  logic [M-1:0][PRECISION-1:0]   buffer, buffer_nx;
  logic [PRECISION-1:0]          data_out_nx;
  logic                          data_valid_nx, burst_last_nx, burst_done_nx;
  logic [CW-1:0]                 idx;
  logic [PRECISION-1:0]          word;

  // Word select written as a compare loop so the index width never has to match the array
  always_comb begin
    idx  = REVERSE ? (LAST_IDX - count) : count;
    word = '0;
    for (int i = 0; i < M; i++) begin
      if (idx == CW'(i)) word = buffer[i];
    end
  end

  always_comb begin
    state_nx      = state;
    count_nx      = count;
    buffer_nx     = buffer;
    data_out_nx   = data_out;
    data_valid_nx = data_valid;
    burst_last_nx = burst_last;
    burst_done_nx = burst_done;
    case (state)
      IDLE: begin
        burst_done_nx = 1'b0;
        if (load) begin
          buffer_nx = data_in;
          count_nx  = '0;
          state_nx  = (INITIAL_LATENCY == 0) ? STREAMING : LATENCY;
        end
      end
      LATENCY: begin
        if (count == LAT_LAST) begin
          count_nx = '0;
          state_nx = STREAMING;
        end else begin
          count_nx = count + 1'b1;
        end
      end
      STREAMING: begin
        // One extra edge after the last word retires the burst
        if (count == M_END) begin
          state_nx      = IDLE;
          data_valid_nx = 1'b0;
          burst_last_nx = 1'b0;
          burst_done_nx = 1'b1;
        end else begin
          data_out_nx   = word;
          data_valid_nx = 1'b1;
          burst_last_nx = (count == LAST_IDX);
          count_nx      = count + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state      <= IDLE;
      count      <= '0;
      buffer     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      burst_last <= 1'b0;
      burst_done <= 1'b0;
    end else if (ce) begin
      state      <= state_nx;
      count      <= count_nx;
      buffer     <= buffer_nx;
      data_out   <= data_out_nx;
      data_valid <= data_valid_nx;
      burst_last <= burst_last_nx;
      burst_done <= burst_done_nx;
    end
  end

  assign ready = (state == IDLE);

endmodule

// File: tb/tb_burst_serializer.sv
// tb/tb_burst_serializer.sv - randomized bench for burst_serializer against a burst-timeline model
module tb_burst_serializer;

  logic             clk = 1'b0;
  logic             clr_n, ce, load;
  logic [4:0][4:0]  din;
  logic [0:0][4:0]  din_min;

  logic       ready0, valid0, last0, done0;
  logic [4:0] out0;
  logic       ready1, valid1, last1, done1;
  logic [4:0] out1;

  int total = 0;
  int bad   = 0;

  // Model state per instance: 0 = defaults (L=3,M=5), 1 = L=0,M=1
  bit         busy [2];
  int         d    [2];
  logic [4:0] mbuf [2][5];
  logic [4:0] e_out   [2];
  logic       e_valid [2];
  logic       e_last  [2];
  logic       e_done  [2];

  assign din_min = din[0];

  always #5 clk = ~clk;

  burst_serializer dut (
    .clk(clk), .clr_n(clr_n), .ce(ce), .load(load), .data_in(din),
    .ready(ready0), .data_out(out0), .data_valid(valid0),
    .burst_last(last0), .burst_done(done0)
  );

  burst_serializer #(.INITIAL_LATENCY(0), .M(1), .PRECISION(5)) dut_min (
    .clk(clk), .clr_n(clr_n), .ce(ce), .load(load), .data_in(din_min),
    .ready(ready1), .data_out(out1), .data_valid(valid1),
    .burst_last(last1), .burst_done(done1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Burst seen as a timeline: d edges after acceptance; words occupy d = L+1 .. L+M, done at L+M+1
  task automatic model_edge(input int n, input int lat, input int m);
    int i, pos;
    if (!clr_n) begin
      busy[n] = 0; d[n] = 0; e_out[n] = '0;
      e_valid[n] = 0; e_last[n] = 0; e_done[n] = 0;
    end else if (ce) begin
      if (busy[n]) begin
        d[n]++;
        if (d[n] >= lat + 1 && d[n] <= lat + m) begin
          i = d[n] - lat - 1;
`ifdef BURST_SERIALIZER_REVERSE_EN
          pos = m - 1 - i;
`else
          pos = i;
`endif
          e_out[n]   = mbuf[n][pos];
          e_valid[n] = 1;
          e_last[n]  = (i == m - 1);
        end else if (d[n] == lat + m + 1) begin
          busy[n] = 0; e_valid[n] = 0; e_last[n] = 0; e_done[n] = 1;
        end
      end else begin
        e_done[n] = 0;
        if (load) begin
          busy[n] = 1; d[n] = 0;
          for (int j = 0; j < m; j++) mbuf[n][j] = din[j];
        end
      end
    end
  endtask

  task automatic step(input logic c_clr, input logic c_ce, input logic c_load);
    clr_n = c_clr; ce = c_ce; load = c_load;
    @(posedge clk);
    model_edge(0, 3, 5);
    model_edge(1, 0, 1);
    #1;
    check_eq("ready",      ready0, !busy[0]);
    check_eq("data_out",   out0,   e_out[0]);
    check_eq("data_valid", valid0, e_valid[0]);
    check_eq("burst_last", last0,  e_last[0]);
    check_eq("burst_done", done0,  e_done[0]);
    check_eq("min_ready",      ready1, !busy[1]);
    check_eq("min_data_out",   out1,   e_out[1]);
    check_eq("min_data_valid", valid1, e_valid[1]);
    check_eq("min_burst_last", last1,  e_last[1]);
    check_eq("min_burst_done", done1,  e_done[1]);
  endtask

  // Load {4,3,2,1,0} at edge 0 with ce held; first word expected at edge 4, done at 9
  task automatic basic_burst();
    int fv0 = -1, dn0 = -1, fv1 = -1, dn1 = -1;
    for (int i = 0; i < 5; i++) din[i] = 5'(i);
    step(1, 1, 1);
    din = 25'h1ffffff;
    for (int e = 1; e <= 12; e++) begin
      step(1, 1, 0);
      if (valid0 && fv0 < 0) fv0 = e;
      if (done0 && dn0 < 0)  dn0 = e;
      if (valid1 && fv1 < 0) fv1 = e;
      if (done1 && dn1 < 0)  dn1 = e;
      if (e == 8) check_eq("last_word_value", out0, `ifdef BURST_SERIALIZER_REVERSE_EN 0 `else 4 `endif);
    end
    check_eq("first_valid_edge", fv0, 4);
    check_eq("done_edge", dn0, 9);
    check_eq("min_first_valid_edge", fv1, 1);
    check_eq("min_done_edge", dn1, 2);
  endtask

  initial begin
    clr_n = 1'b0; ce = 1'b0; load = 1'b0; din = '0;
    for (int n = 0; n < 2; n++) begin
      busy[n] = 0; d[n] = 0; e_out[n] = '0;
      e_valid[n] = 0; e_last[n] = 0; e_done[n] = 0;
      for (int j = 0; j < 5; j++) mbuf[n][j] = '0;
    end
    step(0, 0, 1);
    step(0, 1, 0);
    check_eq("reset_ready", ready0, 1);
    check_eq("reset_data_out", out0, 0);
    check_eq("reset_valid", valid0, 0);

    basic_burst();

    // ce gating: drop ce for 3 cycles after the second word
    for (int i = 0; i < 5; i++) din[i] = 5'(i);
    step(1, 1, 1);
    for (int e = 1; e <= 5; e++) step(1, 1, 0);
    for (int e = 0; e < 3; e++) begin
      step(1, 0, 1);
      check_eq("hold_data_out", out0, `ifdef BURST_SERIALIZER_REVERSE_EN 3 `else 1 `endif);
      check_eq("hold_valid", valid0, 1);
    end
    for (int e = 0; e < 6; e++) step(1, 1, 0);

    // Ignored load during the burst, then back-to-back via load held high
    for (int e = 0; e < 30; e++) begin
      din = 25'($urandom);
      step(1, 1, 1);
    end
    for (int e = 0; e < 10; e++) step(1, 1, 0);

    // Reset mid-burst after the second valid word, then a clean basic burst
    for (int i = 0; i < 5; i++) din[i] = 5'(i + 10);
    step(1, 1, 1);
    for (int e = 1; e <= 5; e++) step(1, 1, 0);
    step(0, 1, 0);
    check_eq("midrst_valid", valid0, 0);
    check_eq("midrst_out", out0, 0);
    check_eq("midrst_ready", ready0, 1);
    for (int e = 0; e < 8; e++) step(1, 1, 0);
    basic_burst();

    // Random traffic: sparse ce, random loads and occasional resets
    for (int e = 0; e < 3000; e++) begin
      din = 25'($urandom);
      step(($urandom % 97) != 0, ($urandom % 4) != 0, $urandom % 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
